// File: rtl/ahb2apb_bridge_mp.sv
// AHB-Lite slave to APB3 master bridge with NUM_SLV one-hot selects,
// PREADY wait states, PSLVERR, decode/size pre-check and ACCESS timeout.
//
// Ports:
//   HCLK, HRESETn                    clock, async active-low reset
//   HTRANS/HWRITE/HREADYin/HADDR     AHB address phase
//   HSIZE/HBURST/HWDATA              AHB size, burst (unused), write data
//   HRDATA/HREADYout/HRESP           AHB response (all registered)
//   PADDR/PSEL/PENABLE/PWRITE/PWDATA APB request (all registered)
//   PRDATA/PREADY/PSLVERR            APB per-slave response buses
module ahb2apb_bridge_mp #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic                      HREADYin,
    input  logic [ADDR_W-1:0]         HADDR,
    input  logic [2:0]                HSIZE,
    input  logic [2:0]                HBURST,
    input  logic [DATA_W-1:0]         HWDATA,
    output logic [DATA_W-1:0]         HRDATA,
    output logic                      HREADYout,
    output logic [1:0]                HRESP,
    output logic [ADDR_W-1:0]         PADDR,
    output logic [NUM_SLV-1:0]        PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RESP, S_ERR1, S_ERR2
    } state_t;

    state_t state, state_n;

    logic [SEL_W-1:0]   sel_q, sel_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SEL_W-1:0]   idx;
    logic               accept;
    logic               bad;
    logic               slv_ready;
    logic               slv_err;
    logic [DATA_W-1:0]  slv_rdata;
    logic [DATA_W-1:0]  hrdata_n;
    logic               hready_n;
    logic [1:0]         hresp_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic [NUM_SLV-1:0] psel_n;
    logic               penable_n;
    logic               pwrite_n;
    logic [DATA_W-1:0]  pwdata_n;
    logic               unused_bits;

    assign unused_bits = ^{HBURST, HTRANS[0]};

    assign idx    = HADDR[SEL_LSB +: SEL_W];
    assign accept = HREADYin && HREADYout && HTRANS[1];
    assign bad    = (32'(idx) >= NUM_SLV) || (HSIZE > MAX_SIZE);

    // PSEL is one-hot and registered, so it doubles as the response mux select.
    assign slv_ready = |(PREADY & PSEL);
    assign slv_err   = |(PSLVERR & PSEL);

    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (PSEL[i]) begin
                slv_rdata = slv_rdata | PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n  = state;
        sel_n    = sel_q;
        cnt_n    = cnt_q;
        paddr_n  = PADDR;
        pwrite_n = PWRITE;
        pwdata_n = PWDATA;
        hrdata_n = '0;
        unique case (state)
            S_IDLE, S_RESP, S_ERR2: begin
                state_n = S_IDLE;
                if (accept) begin
                    if (bad) begin
                        state_n = S_ERR1;
                    end else begin
                        state_n  = HWRITE ? S_WDATA : S_SETUP;
                        sel_n    = idx;
                        paddr_n  = HADDR;
                        pwrite_n = HWRITE;
                    end
                end
            end
            S_WDATA: begin
                pwdata_n = HWDATA;
                state_n  = S_SETUP;
            end
            S_SETUP: state_n = S_ACCESS;
            S_ACCESS: begin
                if (TIMEOUT != 0 && cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + 1'b1;
                end
                if (slv_ready) begin
                    if (slv_err) begin
                        state_n = S_ERR1;
                    end else begin
                        state_n = S_RESP;
                        if (!PWRITE) begin
                            hrdata_n = slv_rdata;
                        end
                    end
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    state_n = S_ERR1;
                end
            end
            S_ERR1:  state_n = S_ERR2;
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_SETUP) begin
            cnt_n = '0;
        end

        // Outputs are decoded from the next state so they appear registered.
        hready_n  = (state_n == S_IDLE) || (state_n == S_RESP) ||
                    (state_n == S_ERR2);
        hresp_n   = ((state_n == S_ERR1) || (state_n == S_ERR2)) ?
                    2'b01 : 2'b00;
        penable_n = (state_n == S_ACCESS);
        psel_n    = ((state_n == S_SETUP) || (state_n == S_ACCESS)) ?
                    (NUM_SLV'(1) << sel_n) : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            HRDATA    <= '0;
            HREADYout <= 1'b1;
            HRESP     <= 2'b00;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            state     <= state_n;
            sel_q     <= sel_n;
            cnt_q     <= cnt_n;
            HRDATA    <= hrdata_n;
            HREADYout <= hready_n;
            HRESP     <= hresp_n;
            PADDR     <= paddr_n;
            PSEL      <= psel_n;
            PENABLE   <= penable_n;
            PWRITE    <= pwrite_n;
            PWDATA    <= pwdata_n;
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge_mp.sv
// Scoreboard bench for ahb2apb_bridge_mp: AHB master stimulus, APB slave
// model, and an AHB response monitor checking against queued expectations.
module tb_ahb2apb_bridge_mp;

    // Three slaves: index 3 in the 2-bit select field is a decode miss.
    localparam int NS = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic           HCLK = 1'b0;
    logic           HRESETn;
    logic [1:0]     HTRANS;
    logic           HWRITE;
    logic           HREADYin;
    logic [AW-1:0]  HADDR;
    logic [2:0]     HSIZE;
    logic [2:0]     HBURST;
    logic [DW-1:0]  HWDATA;
    logic [DW-1:0]  HRDATA;
    logic           HREADYout;
    logic [1:0]     HRESP;
    logic [AW-1:0]  PADDR;
    logic [NS-1:0]  PSEL;
    logic           PENABLE;
    logic           PWRITE;
    logic [DW-1:0]  PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  PSLVERR;

    int checks = 0;
    int failures = 0;

    always #5 HCLK = ~HCLK;

    assign HREADYin = HREADYout;

    ahb2apb_bridge_mp #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .SEL_LSB(12), .TIMEOUT(TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HREADYin(HREADYin), .HADDR(HADDR), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYout(HREADYout),
        .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic          wr;
        logic          err;
        logic [DW-1:0] rdata;
        int            lat;
    } exp_t;

    typedef struct {
        int               slv;
        logic [AW-1:0]    addr;
        logic             wr;
        logic [DW-1:0]    wdata;
        int               waits;
        logic             serr;
        logic [NS*DW-1:0] prdata;
    } apb_t;

    exp_t sb_q[$];
    apb_t apb_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // AHB response monitor: tracks accepts and data-phase completions.
    int   ncyc = 0;
    bit   pending = 0;
    int   acc_n = 0;
    int   pipelined = 0;
    logic prev_rdy = 1'b1;
    logic [1:0] prev_resp = 2'b00;

    always @(negedge HCLK) begin
        exp_t e;
        bit   done;
        ncyc++;
        done = 0;
        if (!HRESETn) begin
            pending = 0;
        end else begin
            if (pending && HREADYout) begin
                done = 1;
                pending = 0;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: completion with no expectation");
                end else begin
                    e = sb_q.pop_front();
                    chk("hresp", 64'(HRESP), 64'(e.err ? 2'b01 : 2'b00));
                    chk("latency", 64'(ncyc - acc_n), 64'(e.lat));
                    if (e.err) begin
                        chk("err_first_cycle", 64'({prev_rdy, prev_resp}),
                            64'(3'b001));
                    end else begin
                        chk("hrdata", 64'(HRDATA),
                            64'(e.wr ? '0 : e.rdata));
                    end
                end
            end
            if (HREADYout && HTRANS[1]) begin
                pending = 1;
                acc_n = ncyc;
                if (done) pipelined++;
            end
        end
        prev_rdy = HREADYout;
        prev_resp = HRESP;
    end

    // APB slave model driven from the queued per-transfer behaviour.
    apb_t cur;
    int   acc = 0;

    always @(posedge HCLK) begin
        #1;
        checks++;
        if ($countones(PSEL) > 1) begin
            failures++;
            $display("FAIL psel_onehot: got %b expected at most one bit", PSEL);
        end
        if (PSEL != '0 && !PENABLE) begin
            if (apb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_apb: psel %b expected 0", PSEL);
            end else begin
                cur = apb_q.pop_front();
                acc = 0;
                PRDATA = cur.prdata;
                chk("setup_psel", 64'(PSEL), 64'(NS'(1) << cur.slv));
                chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
                chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
                if (cur.wr) chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
            end
            PREADY = '0;
            PSLVERR = '0;
        end else if (PSEL != '0) begin
            chk("acc_psel", 64'(PSEL), 64'(NS'(1) << cur.slv));
            chk("acc_paddr", 64'(PADDR), 64'(cur.addr));
            chk("acc_pwrite", 64'(PWRITE), 64'(cur.wr));
            if (cur.wr) chk("acc_pwdata", 64'(PWDATA), 64'(cur.wdata));
            PREADY = NS'($urandom);
            PSLVERR = NS'($urandom);
            PREADY[cur.slv] = (acc == cur.waits);
            PSLVERR[cur.slv] = cur.serr;
            acc++;
        end else begin
            PREADY = NS'($urandom);
            PSLVERR = NS'($urandom);
        end
    end

    // Issue one AHB transfer; returns just after its accept edge.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr,
                           input logic [2:0] size, input int waits,
                           input logic serr, input logic [DW-1:0] rd,
                           input logic [DW-1:0] wd);
        exp_t e;
        apb_t a;
        int   idx;
        bit   bad;
        bit   to;
        int   acc_cyc;
        int   n;
        idx = int'(addr[13:12]);
        bad = (idx >= NS) || (size > 3'd2);
        a.slv = idx;
        a.addr = addr;
        a.wr = wr;
        a.wdata = wd;
        a.waits = waits;
        a.serr = serr;
        for (int i = 0; i < NS; i++) a.prdata[i*DW +: DW] = $urandom;
        e.wr = wr;
        e.rdata = rd;
        if (bad) begin
            e.err = 1'b1;
            e.lat = 2;
        end else begin
            a.prdata[idx*DW +: DW] = rd;
            to = (waits >= TO);
            acc_cyc = to ? TO : waits + 1;
            e.err = to || serr;
            e.lat = (wr ? 4 : 3) + acc_cyc - 1 + (e.err ? 1 : 0);
            apb_q.push_back(a);
        end
        sb_q.push_back(e);
        HTRANS = {1'b1, 1'($urandom)};
        HADDR = addr;
        HWRITE = wr;
        HSIZE = size;
        HBURST = 3'($urandom);
        n = 0;
        @(negedge HCLK);
        while (!HREADYout && n < 200) begin
            @(negedge HCLK);
            n++;
        end
        if (!HREADYout) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: hreadyout %b expected 1", HREADYout);
        end
        @(posedge HCLK);
        #1;
        HTRANS = 2'b00;
        HWDATA = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            HTRANS = {1'b0, 1'($urandom)};
            @(posedge HCLK);
            #1;
        end
        HTRANS = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || pending) && n < 500) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || pending) begin
            failures++;
            $display("FAIL drain: %0d responses outstanding expected 0",
                     sb_q.size());
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_hready", 64'(HREADYout), 64'(1'b1));
        chk("rst_hresp", 64'(HRESP), 64'(2'b00));
        chk("rst_hrdata", 64'(HRDATA), 64'(0));
        chk("rst_psel", 64'(PSEL), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
    endtask

    initial begin
        logic          wr;
        logic [AW-1:0] addr;
        logic [2:0]    size;
        int            waits;
        logic          serr;
        int            p0;
        int            n;
        int            sidx;

        HRESETn = 1'b1;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR = '0;
        HSIZE = 3'd0;
        HBURST = 3'd0;
        HWDATA = '0;
        PRDATA = '0;
        PREADY = '0;
        PSLVERR = '0;
        #2 HRESETn = 1'b0;
        #2 chk_reset_vals();
        repeat (3) @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        do_xfer(1'b0, 32'h0000_2004, 3'd2, 0, 1'b0, 32'hDEAD_BEEF, $urandom);
        drain();
        do_xfer(1'b1, 32'h0000_1010, 3'd2, 3, 1'b0, $urandom, 32'hA5A5_0001);
        drain();
        do_xfer(1'b0, 32'h0000_1000, 3'd2, 0, 1'b1, $urandom, $urandom);
        drain();
        do_xfer(1'b0, 32'h0000_3000, 3'd2, 0, 1'b0, $urandom, $urandom);
        drain();
        do_xfer(1'b1, 32'h0000_0000, 3'd3, 0, 1'b0, $urandom, $urandom);
        drain();
        do_xfer(1'b0, 32'h0000_2008, 3'd2, 50, 1'b0, $urandom, $urandom);
        drain();

        p0 = pipelined;
        do_xfer(1'b0, 32'h0000_0010, 3'd2, 0, 1'b0, $urandom, $urandom);
        do_xfer(1'b1, 32'h0000_1020, 3'd1, 0, 1'b0, $urandom, $urandom);
        drain();
        chk("b2b_pipelined", 64'(pipelined - p0), 64'(1));

        for (int k = 0; k < 150; k++) begin
            wr = 1'($urandom);
            sidx = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            addr = ($urandom & 32'hFFFF_0FFC) | (32'(sidx) << 12);
            size = ($urandom_range(0, 9) == 0) ? 3'd3 :
                   3'($urandom_range(0, 2));
            waits = ($urandom_range(0, 7) < 2) ? $urandom_range(6, 9) :
                    $urandom_range(0, 3);
            serr = ($urandom_range(0, 7) == 0);
            do_xfer(wr, addr, size, waits, serr, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();

        do_xfer(1'b0, 32'h0000_0008, 3'd2, 30, 1'b0, $urandom, $urandom);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        chk("reach_access", 64'(PENABLE), 64'(1'b1));
        @(posedge HCLK);
        #2 HRESETn = 1'b0;
        #1 chk_reset_vals();
        sb_q.delete();
        apb_q.delete();
        @(negedge HCLK);
        #1 HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        do_xfer(1'b0, 32'h0000_2000, 3'd2, 1, 1'b0, $urandom, $urandom);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
